ex_operand_stage: RTL and testbench

//  ID/EX pipeline register directly upstream of alu. Captures decoded instructions.

---
 rtl/ex_operand_stage_pkg.sv | 29 ++
 rtl/ex_operand_stage_fwd_mux.sv | 41 ++++
 rtl/ex_operand_stage.sv | 149 ++++++++++++++
 tb/tb_ex_operand_stage.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ex_operand_stage_pkg.sv
// Shared core constants for the operand stage: datapath widths, ALU op codes
// and the forwarding-source select type.
package ex_operand_stage_pkg;

  localparam int CORE_XLEN       = 32;
  localparam int CORE_ALU_INST_W = 5;
  localparam int CORE_REG_AW     = 5;

  // Code 0 is the bubble op, so cleared pipeline state always reads as a NOP.
  localparam logic [CORE_ALU_INST_W-1:0] ALU_NOP       = 5'd0;
  localparam logic [CORE_ALU_INST_W-1:0] ALU_ADD       = 5'd1;
  localparam logic [CORE_ALU_INST_W-1:0] ALU_SUB       = 5'd2;
  localparam logic [CORE_ALU_INST_W-1:0] ALU_AND       = 5'd3;
  localparam logic [CORE_ALU_INST_W-1:0] ALU_OR        = 5'd4;
  localparam logic [CORE_ALU_INST_W-1:0] ALU_XOR       = 5'd5;
  localparam logic [CORE_ALU_INST_W-1:0] ALU_SLL       = 5'd6;
  localparam logic [CORE_ALU_INST_W-1:0] ALU_SRL       = 5'd7;
  localparam logic [CORE_ALU_INST_W-1:0] ALU_SRA       = 5'd8;
  localparam logic [CORE_ALU_INST_W-1:0] ALU_CMP_LESS  = 5'd9;
  localparam logic [CORE_ALU_INST_W-1:0] ALU_CMP_LESSU = 5'd10;
  localparam logic [CORE_ALU_INST_W-1:0] ALU_CMP_EQ    = 5'd11;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_MEMWB = 2'd1,
    FWD_EXMEM = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Per-operand bypass select: EX/MEM beats MEM/WB beats the register file.
// Register x0 never takes a bypassed value.
module ex_fwd_mux
  import ex_operand_stage_pkg::*;
#(
  parameter int XLEN   = CORE_XLEN,
  parameter int REG_AW = CORE_REG_AW
) (
  input  logic [REG_AW-1:0] rs_addr_i,
  input  logic [XLEN-1:0]   rf_data_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic              exmem_wen_i,
  input  logic [XLEN-1:0]   exmem_data_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic              memwb_wen_i,
  input  logic [XLEN-1:0]   memwb_data_i,
  output logic [XLEN-1:0]   data_o
);

  fwd_sel_e sel;
  logic     exmem_hit;
  logic     memwb_hit;

  always_comb begin
    exmem_hit = exmem_wen_i && (exmem_rd_i != '0) && (exmem_rd_i == rs_addr_i);
    memwb_hit = memwb_wen_i && (memwb_rd_i != '0) && (memwb_rd_i == rs_addr_i);
    sel = FWD_RF;
    if (memwb_hit) sel = FWD_MEMWB;
    if (exmem_hit) sel = FWD_EXMEM;
  end

  always_comb begin
    data_o = rf_data_i;
    unique case (sel)
      FWD_EXMEM: data_o = exmem_data_i;
      FWD_MEMWB: data_o = memwb_data_i;
      default:   data_o = rf_data_i;
    endcase
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU: operand bypass, immediate
// sign-extension, operand select and load-use bubble insertion.
module ex_operand_stage
  import ex_operand_stage_pkg::*;
#(
  parameter int XLEN       = CORE_XLEN,
  parameter int ALU_INST_W = CORE_ALU_INST_W,
  parameter int REG_AW     = CORE_REG_AW
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic [ALU_INST_W-1:0] alu_inst_i,
  input  logic [XLEN-1:0]       pc_i,
  input  logic [REG_AW-1:0]     rs1_addr_i,
  input  logic [REG_AW-1:0]     rs2_addr_i,
  input  logic [XLEN-1:0]       rs1_data_i,
  input  logic [XLEN-1:0]       rs2_data_i,
  input  logic [11:0]           imm12_i,
  input  logic                  use_imm_i,
  input  logic                  use_pc_i,
  input  logic [REG_AW-1:0]     rd_addr_i,
  input  logic                  rd_wen_i,
  input  logic                  mem_rd_i,
  input  logic [REG_AW-1:0]     exmem_rd_i,
  input  logic                  exmem_wen_i,
  input  logic [XLEN-1:0]       exmem_data_i,
  input  logic [REG_AW-1:0]     memwb_rd_i,
  input  logic                  memwb_wen_i,
  input  logic [XLEN-1:0]       memwb_data_i,
  output logic                  alu_valid_o,
  output logic [ALU_INST_W-1:0] alu_inst_o,
  output logic [XLEN-1:0]       alu_src1_o,
  output logic [XLEN-1:0]       alu_src2_o,
  output logic [XLEN-1:0]       rs2_fwd_o,
  output logic [REG_AW-1:0]     rd_addr_o,
  output logic                  rd_wen_o,
  output logic                  mem_rd_o
);

  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;
  logic [XLEN-1:0] imm_sext;
  logic            load_use;

  logic                  valid_q,  valid_d;
  logic [ALU_INST_W-1:0] inst_q,   inst_d;
  logic [XLEN-1:0]       src1_q,   src1_d;
  logic [XLEN-1:0]       src2_q,   src2_d;
  logic [XLEN-1:0]       rs2f_q,   rs2f_d;
  logic [REG_AW-1:0]     rd_q,     rd_d;
  logic                  rd_wen_q, rd_wen_d;
  logic                  mem_rd_q, mem_rd_d;

  ex_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
    .rs_addr_i    (rs1_addr_i),
    .rf_data_i    (rs1_data_i),
    .exmem_rd_i   (exmem_rd_i),
    .exmem_wen_i  (exmem_wen_i),
    .exmem_data_i (exmem_data_i),
    .memwb_rd_i   (memwb_rd_i),
    .memwb_wen_i  (memwb_wen_i),
    .memwb_data_i (memwb_data_i),
    .data_o       (rs1_fwd)
  );

  ex_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
    .rs_addr_i    (rs2_addr_i),
    .rf_data_i    (rs2_data_i),
    .exmem_rd_i   (exmem_rd_i),
    .exmem_wen_i  (exmem_wen_i),
    .exmem_data_i (exmem_data_i),
    .memwb_rd_i   (memwb_rd_i),
    .memwb_wen_i  (memwb_wen_i),
    .memwb_data_i (memwb_data_i),
    .data_o       (rs2_fwd)
  );

  assign imm_sext = {{(XLEN-12){imm12_i[11]}}, imm12_i};

  // A load sitting in EX has no data yet; an immediate-form consumer does not read rs2.
  always_comb begin
    load_use = valid_q && mem_rd_q && (rd_q != '0) && valid_i &&
               ((rd_q == rs1_addr_i) || ((rd_q == rs2_addr_i) && !use_imm_i));
  end

  assign ready_o = !stall_i && !load_use;

  always_comb begin
    valid_d  = valid_q;
    inst_d   = inst_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    rs2f_d   = rs2f_q;
    rd_d     = rd_q;
    rd_wen_d = rd_wen_q;
    mem_rd_d = mem_rd_q;
    if (flush_i || (!stall_i && (load_use || !valid_i))) begin
      valid_d  = 1'b0;
      inst_d   = ALU_NOP;
      rd_wen_d = 1'b0;
      mem_rd_d = 1'b0;
    end else if (!stall_i) begin
      valid_d  = 1'b1;
      inst_d   = alu_inst_i;
      src1_d   = use_pc_i  ? pc_i     : rs1_fwd;
      src2_d   = use_imm_i ? imm_sext : rs2_fwd;
      rs2f_d   = rs2_fwd;
      rd_d     = rd_addr_i;
      rd_wen_d = rd_wen_i;
      mem_rd_d = mem_rd_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q  <= 1'b0;
      inst_q   <= ALU_NOP;
      src1_q   <= '0;
      src2_q   <= '0;
      rs2f_q   <= '0;
      rd_q     <= '0;
      rd_wen_q <= 1'b0;
      mem_rd_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      inst_q   <= inst_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      rs2f_q   <= rs2f_d;
      rd_q     <= rd_d;
      rd_wen_q <= rd_wen_d;
      mem_rd_q <= mem_rd_d;
    end
  end

  assign alu_valid_o = valid_q;
  assign alu_inst_o  = inst_q;
  assign alu_src1_o  = src1_q;
  assign alu_src2_o  = src2_q;
  assign rs2_fwd_o   = rs2f_q;
  assign rd_addr_o   = rd_q;
  assign rd_wen_o    = rd_wen_q;
  assign mem_rd_o    = mem_rd_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Randomized bench for ex_operand_stage against a cycle-level behavioural model,
// plus directed cases for reset, immediates, bypass, load-use and stall/flush.
module tb_ex_operand_stage;
  import ex_operand_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i, ready_o, stall_i, flush_i;
  logic [4:0]  alu_inst_i;
  logic [31:0] pc_i, rs1_data_i, rs2_data_i;
  logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i;
  logic [11:0] imm12_i;
  logic        use_imm_i, use_pc_i, rd_wen_i, mem_rd_i;
  logic [4:0]  exmem_rd_i, memwb_rd_i;
  logic        exmem_wen_i, memwb_wen_i;
  logic [31:0] exmem_data_i, memwb_data_i;
  logic        alu_valid_o, rd_wen_o, mem_rd_o;
  logic [4:0]  alu_inst_o, rd_addr_o;
  logic [31:0] alu_src1_o, alu_src2_o, rs2_fwd_o;

  int checks = 0;
  int errors = 0;

  // Model of what the stage should be presenting to the ALU.
  logic        m_valid, m_wen, m_memrd;
  logic [4:0]  m_inst, m_rd;
  logic [31:0] m_src1, m_src2, m_rs2f;

  ex_operand_stage dut (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .stall_i(stall_i), .flush_i(flush_i), .alu_inst_i(alu_inst_i), .pc_i(pc_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .imm12_i(imm12_i), .use_imm_i(use_imm_i), .use_pc_i(use_pc_i),
    .rd_addr_i(rd_addr_i), .rd_wen_i(rd_wen_i), .mem_rd_i(mem_rd_i),
    .exmem_rd_i(exmem_rd_i), .exmem_wen_i(exmem_wen_i), .exmem_data_i(exmem_data_i),
    .memwb_rd_i(memwb_rd_i), .memwb_wen_i(memwb_wen_i), .memwb_data_i(memwb_data_i),
    .alu_valid_o(alu_valid_o), .alu_inst_o(alu_inst_o),
    .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o), .rs2_fwd_o(rs2_fwd_o),
    .rd_addr_o(rd_addr_o), .rd_wen_o(rd_wen_o), .mem_rd_o(mem_rd_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h @%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_operand(input logic [4:0] a, input logic [31:0] rf);
    if (a == 0) return rf;
    if (exmem_wen_i && exmem_rd_i == a) return exmem_data_i;
    if (memwb_wen_i && memwb_rd_i == a) return memwb_data_i;
    return rf;
  endfunction

  task automatic model_clear();
    m_valid = 0; m_wen = 0; m_memrd = 0; m_inst = 0;
    m_rd = 0; m_src1 = 0; m_src2 = 0; m_rs2f = 0;
  endtask

  task automatic idle();
    valid_i = 0; stall_i = 0; flush_i = 0; alu_inst_i = 0; pc_i = 0;
    rs1_addr_i = 0; rs2_addr_i = 0; rs1_data_i = 0; rs2_data_i = 0; imm12_i = 0;
    use_imm_i = 0; use_pc_i = 0; rd_addr_i = 0; rd_wen_i = 0; mem_rd_i = 0;
    exmem_rd_i = 0; exmem_wen_i = 0; exmem_data_i = 0;
    memwb_rd_i = 0; memwb_wen_i = 0; memwb_data_i = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"}, 32'(alu_valid_o), 32'(m_valid));
    chk({tag, ".inst"},  32'(alu_inst_o),  32'(m_inst));
    chk({tag, ".wen"},   32'(rd_wen_o),    32'(m_wen));
    chk({tag, ".memrd"}, 32'(mem_rd_o),    32'(m_memrd));
    if (m_valid) begin
      chk({tag, ".src1"}, alu_src1_o, m_src1);
      chk({tag, ".src2"}, alu_src2_o, m_src2);
      chk({tag, ".rs2f"}, rs2_fwd_o,  m_rs2f);
      chk({tag, ".rd"},   32'(rd_addr_o), 32'(m_rd));
    end
  endtask

  // One clock: check ready against the hazard rule, advance the model, compare outputs.
  task automatic tick(input string tag);
    logic hazard;
    logic [31:0] s1, s2, r2;
    #1;
    hazard = m_valid && m_memrd && m_rd != 0 && valid_i &&
             (m_rd == rs1_addr_i || (m_rd == rs2_addr_i && !use_imm_i));
    chk({tag, ".ready"}, 32'(ready_o), 32'(!stall_i && !hazard));
    r2 = ref_operand(rs2_addr_i, rs2_data_i);
    s1 = use_pc_i ? pc_i : ref_operand(rs1_addr_i, rs1_data_i);
    s2 = use_imm_i ? {{20{imm12_i[11]}}, imm12_i} : r2;
    @(posedge clk);
    #1;
    if (flush_i) begin
      m_valid = 0; m_wen = 0; m_memrd = 0; m_inst = 0;
    end else if (stall_i) begin
      // nothing moves
    end else if (hazard || !valid_i) begin
      m_valid = 0; m_wen = 0; m_memrd = 0; m_inst = 0;
    end else begin
      m_valid = 1; m_inst = alu_inst_i; m_src1 = s1; m_src2 = s2; m_rs2f = r2;
      m_rd = rd_addr_i; m_wen = rd_wen_i; m_memrd = mem_rd_i;
    end
    check_outputs(tag);
  endtask

  task automatic rand_inputs();
    valid_i      = ($urandom_range(0, 3) != 0);
    stall_i      = ($urandom_range(0, 4) == 0);
    flush_i      = ($urandom_range(0, 9) == 0);
    alu_inst_i   = 5'($urandom_range(0, 11));
    pc_i         = $urandom;
    rs1_addr_i   = 5'($urandom_range(0, 7));
    rs2_addr_i   = 5'($urandom_range(0, 7));
    rs1_data_i   = $urandom;
    rs2_data_i   = $urandom;
    imm12_i      = 12'($urandom);
    use_imm_i    = $urandom_range(0, 1) != 0;
    use_pc_i     = $urandom_range(0, 3) == 0;
    rd_addr_i    = 5'($urandom_range(0, 7));
    rd_wen_i     = $urandom_range(0, 1) != 0;
    mem_rd_i     = $urandom_range(0, 2) == 0;
    exmem_rd_i   = 5'($urandom_range(0, 7));
    exmem_wen_i  = $urandom_range(0, 1) != 0;
    exmem_data_i = $urandom;
    memwb_rd_i   = 5'($urandom_range(0, 7));
    memwb_wen_i  = $urandom_range(0, 1) != 0;
    memwb_data_i = $urandom;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".valid"}, 32'(alu_valid_o), 0);
    chk({tag, ".inst"},  32'(alu_inst_o), 0);
    chk({tag, ".src1"},  alu_src1_o, 0);
    chk({tag, ".src2"},  alu_src2_o, 0);
    chk({tag, ".rs2f"},  rs2_fwd_o, 0);
    chk({tag, ".rd"},    32'(rd_addr_o), 0);
    chk({tag, ".wen"},   32'(rd_wen_o), 0);
    chk({tag, ".memrd"}, 32'(mem_rd_o), 0);
  endtask

  initial begin
    idle();
    model_clear();
    rst_n = 0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1;
    tick("idle");

    // Negative immediate with an unsigned compare.
    valid_i = 1; use_imm_i = 1; imm12_i = 12'hFFF; rs1_addr_i = 3;
    rs1_data_i = 32'h8FFFFF00; alu_inst_i = ALU_CMP_LESSU; rd_addr_i = 4; rd_wen_i = 1;
    tick("imm");
    chk("imm.src2_const", alu_src2_o, 32'hFFFFFFFF);
    chk("imm.src1_const", alu_src1_o, 32'h8FFFFF00);
    chk("imm.inst_const", 32'(alu_inst_o), 32'(ALU_CMP_LESSU));

    // Bypass priority.
    idle(); valid_i = 1; rs1_addr_i = 5; rs1_data_i = 32'hC;
    exmem_rd_i = 5; exmem_wen_i = 1; exmem_data_i = 32'hA;
    memwb_rd_i = 5; memwb_wen_i = 1; memwb_data_i = 32'hB;
    tick("fwd_exmem");
    chk("fwd_exmem.const", alu_src1_o, 32'hA);
    exmem_wen_i = 0;
    tick("fwd_memwb");
    chk("fwd_memwb.const", alu_src1_o, 32'hB);
    rs1_addr_i = 0; exmem_rd_i = 0; exmem_wen_i = 1; memwb_rd_i = 0; rs1_data_i = 32'h1234;
    tick("fwd_x0");
    chk("fwd_x0.const", alu_src1_o, 32'h1234);

    // Load-use on rs2.
    idle(); valid_i = 1; mem_rd_i = 1; rd_addr_i = 7; rd_wen_i = 1; rs1_addr_i = 1; rs2_addr_i = 2;
    tick("lu_load");
    idle(); valid_i = 1; rs1_addr_i = 1; rs2_addr_i = 7; rs2_data_i = 32'h55;
    #1;
    chk("lu.ready_low", 32'(ready_o), 0);
    tick("lu_bubble");
    chk("lu.bubble", 32'(alu_valid_o), 0);
    exmem_rd_i = 7; exmem_wen_i = 1; exmem_data_i = 32'h77;
    tick("lu_accept");
    chk("lu.src2_fwd", alu_src2_o, 32'h77);
    chk("lu.valid", 32'(alu_valid_o), 1);
    idle(); valid_i = 1; mem_rd_i = 1; rd_addr_i = 7; rd_wen_i = 1;
    tick("lu_load2");
    idle(); valid_i = 1; rs1_addr_i = 1; rs2_addr_i = 7; use_imm_i = 1; imm12_i = 12'h010;
    tick("lu_imm");
    chk("lu_imm.valid", 32'(alu_valid_o), 1);

    // Stall holds, flush overrides stall.
    idle(); valid_i = 1; rd_addr_i = 9; rd_wen_i = 1; rs1_data_i = 32'hDEAD; rs1_addr_i = 1;
    tick("pre_stall");
    stall_i = 1; rs1_data_i = 32'hBEEF; rd_addr_i = 10;
    for (int i = 0; i < 3; i++) tick("stall");
    chk("stall.src1_held", alu_src1_o, 32'hDEAD);
    flush_i = 1;
    tick("flush_stall");
    chk("flush.wen", 32'(rd_wen_o), 0);

    for (int i = 0; i < 200; i++) begin
      rand_inputs();
      tick("rand");
    end

    // Asynchronous reset in the middle of traffic.
    idle(); valid_i = 1; rd_wen_i = 1; mem_rd_i = 1; rd_addr_i = 3; alu_inst_i = ALU_ADD;
    rs1_data_i = 32'h1111; rs2_data_i = 32'h2222;
    tick("pre_rst");
    rst_n = 0;
    #1;
    check_all_zero("mid_rst");
    model_clear();
    idle();
    @(negedge clk);
    rst_n = 1;
    tick("post_rst");
    tick("post_rst2");

    for (int i = 0; i < 200; i++) begin
      rand_inputs();
      tick("rand2");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
